unidade_busca: RTL and testbench

Instruction fetch sequencer feeding the main control unit's opcode input and consuming its sinalBranch result.
- Holds the PC and fetches one 32-bit word per instruction from instruction memory over a req/valid handshake.
- Presents the word and its opcode to the datapath and control until the datapath accepts it.
- Computes the next PC as sequential (+4) or as a taken branch (sinalBranch AND zero).
- Forces opcode 7'b0000000 whenever no instruction is valid, so the control unit emits all-zero (no-write) controls.

---
 rtl/unidade_busca.sv | 168 ++++++++++++++++
 tb/tb_unidade_busca.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_busca.sv
// -----------------------------------------------------------------------------
// unidade_busca -- instruction fetch sequencer
//
// Holds the program counter, fetches one 32-bit word per instruction from
// instruction memory over a req/valid handshake, presents it to the datapath
// and control unit until the datapath retires it, then advances the PC either
// sequentially (+4) or to a taken branch target (sinalBranch AND zero).
// Whenever no instruction is valid the opcode output is forced to zero so the
// control unit decodes a harmless no-write instruction.
//
// Parameters:
//   LARGURA_PC : width of PC, fetch address and branch offset
//   PC_RESET   : PC loaded on reset (4-byte aligned)
//   TIMEOUT    : max BUSCA cycles without imem_valid before fault (>= 1)
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   imem_req      : out, fetch request (high only while fetching)
//   imem_addr     : out, fetch address (equals pc_atual)
//   imem_valid    : in,  memory returns imem_data this cycle
//   imem_data     : in,  fetched instruction word
//   instrucao     : out, registered current instruction
//   opcode        : out, instrucao[6:0] while valid, else 7'b0000000
//   instr_valida  : out, instrucao is valid for datapath/control
//   avanca        : in,  datapath retires the current instruction
//   sinalBranch   : in,  branch control from control unit
//   zero          : in,  ALU zero flag
//   imm_branch    : in,  sign-extended branch byte offset
//   pc_atual      : out, current PC register
//   erro_busca    : out, sticky fault (fetch timeout or misaligned target)
// -----------------------------------------------------------------------------
module unidade_busca #(
  parameter int                    LARGURA_PC = 32,
  parameter logic [LARGURA_PC-1:0] PC_RESET   = '0,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [LARGURA_PC-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [31:0]           imem_data,
  output logic [31:0]           instrucao,
  output logic [6:0]            opcode,
  output logic                  instr_valida,
  input  logic                  avanca,
  input  logic                  sinalBranch,
  input  logic                  zero,
  input  logic [LARGURA_PC-1:0] imm_branch,
  output logic [LARGURA_PC-1:0] pc_atual,
  output logic                  erro_busca
);

  // Counter must be able to hold TIMEOUT-1 (the last legal waiting cycle).
  localparam int LARGURA_CONT = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [LARGURA_CONT-1:0] CONT_LIMITE = LARGURA_CONT'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    BUSCA  = 2'd1,
    EMITE  = 2'd2,
    ERRO   = 2'd3
  } estado_t;

  estado_t                 r_estado;
  estado_t                 w_estado_next;
  logic [LARGURA_PC-1:0]   r_pc;
  logic [LARGURA_PC-1:0]   w_pc_next;
  logic [31:0]             r_instrucao;
  logic [31:0]             w_instrucao_next;
  logic [LARGURA_CONT-1:0] r_cont;
  logic [LARGURA_CONT-1:0] w_cont_next;
  logic                    r_req;
  logic                    r_valida;
  logic                    r_erro;
  logic [LARGURA_PC-1:0]   w_alvo;
  logic                    w_desvio;

  // Branch is taken only when the control unit asks for it and the ALU
  // comparison succeeded; the sum wraps silently modulo 2^LARGURA_PC.
  assign w_desvio = sinalBranch && zero;
  assign w_alvo   = w_desvio ? (r_pc + imm_branch) : (r_pc + LARGURA_PC'(4));

  // ---------------------------------------------------------------------------
  // Next-state / next-data logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_estado_next    = r_estado;
    w_pc_next        = r_pc;
    w_instrucao_next = r_instrucao;
    w_cont_next      = r_cont;

    case (r_estado)
      OCIOSO: begin
        w_estado_next = BUSCA;
      end

      BUSCA: begin
        // A response on the last legal cycle still wins over the timeout.
        if (imem_valid) begin
          w_instrucao_next = imem_data;
          w_cont_next      = '0;
          w_estado_next    = EMITE;
        end else if (r_cont == CONT_LIMITE) begin
          w_cont_next   = '0;
          w_estado_next = ERRO;
        end else begin
          w_cont_next = r_cont + LARGURA_CONT'(1);
        end
      end

      EMITE: begin
        // Branch inputs only matter on the retiring cycle.
        if (avanca) begin
          if (w_alvo[1:0] == 2'b00) begin
            w_pc_next     = w_alvo;
            w_estado_next = BUSCA;
          end else begin
            // Misaligned target: keep the PC of the offending instruction.
            w_estado_next = ERRO;
          end
        end
      end

      ERRO: begin
        w_estado_next = ERRO;
      end

      default: begin
        w_estado_next = ERRO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and data registers. Output decodes are registered from the next
  // state so they line up exactly with the state they describe.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado    <= OCIOSO;
      r_pc        <= PC_RESET;
      r_instrucao <= '0;
      r_cont      <= '0;
      r_req       <= 1'b0;
      r_valida    <= 1'b0;
      r_erro      <= 1'b0;
    end else begin
      r_estado    <= w_estado_next;
      r_pc        <= w_pc_next;
      r_instrucao <= w_instrucao_next;
      r_cont      <= w_cont_next;
      r_req       <= (w_estado_next == BUSCA);
      r_valida    <= (w_estado_next == EMITE);
      r_erro      <= (w_estado_next == ERRO);
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_pc;
  assign pc_atual     = r_pc;
  assign instrucao    = r_instrucao;
  assign instr_valida = r_valida;
  assign erro_busca   = r_erro;
  // Zero opcode outside EMITE makes the control unit emit no-write controls.
  assign opcode       = r_valida ? r_instrucao[6:0] : 7'b0000000;

endmodule

// File: tb/tb_unidade_busca.sv
module tb_unidade_busca;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst1 = 1'b1;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_data = '0;
  logic        avanca = 1'b0;
  logic        sinalBranch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] imm_branch = '0;

  logic        imem_req, instr_valida, erro_busca;
  logic [31:0] imem_addr, instrucao, pc_atual;
  logic [6:0]  opcode;

  logic        imem_req1, instr_valida1, erro_busca1;
  logic [31:0] imem_addr1, instrucao1, pc_atual1;
  logic [6:0]  opcode1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  unidade_busca #(.LARGURA_PC(32), .PC_RESET(32'h0), .TIMEOUT(15)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .instrucao(instrucao),
    .opcode(opcode), .instr_valida(instr_valida), .avanca(avanca),
    .sinalBranch(sinalBranch), .zero(zero), .imm_branch(imm_branch),
    .pc_atual(pc_atual), .erro_busca(erro_busca)
  );

  unidade_busca #(.LARGURA_PC(32), .PC_RESET(32'h100), .TIMEOUT(15)) u_dut1 (
    .clk(clk), .rst(rst1), .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_valid(imem_valid), .imem_data(imem_data), .instrucao(instrucao1),
    .opcode(opcode1), .instr_valida(instr_valida1), .avanca(avanca),
    .sinalBranch(sinalBranch), .zero(zero), .imm_branch(imm_branch),
    .pc_atual(pc_atual1), .erro_busca(erro_busca1)
  );

  typedef struct {
    logic [31:0] instr;
    logic        sb;
    logic        z;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [31:0] nxt;
  } vec_t;

  vec_t tab[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    // Asynchronous clear, visible before any clock edge.
    chk("rst_async_req", {31'b0, imem_req}, 32'h0);
    step();
    step();
    chk("rst_pc", pc_atual, 32'h0);
    chk("rst_flags", {28'b0, imem_req, instr_valida, erro_busca, |opcode}, 32'h0);
    chk("rst_instr", instrucao, 32'h0);
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(32'h0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("req_seen", {31'b0, imem_req}, 32'h1);
  endtask

  task automatic fetch(input logic [31:0] instr, input logic [6:0] exp_op);
    logic [31:0] ea;
    wait_req();
    if (exp_q.size() == 0) begin
      ea = 32'hDEAD_BEEF;
    end else begin
      ea = exp_q.pop_front();
    end
    chk("imem_addr", imem_addr, ea);
    chk("busca_op_zero", {25'b0, opcode}, 32'h0);
    chk("busca_not_valid", {31'b0, instr_valida}, 32'h0);
    imem_valid = 1'b1;
    imem_data  = instr;
    step();
    imem_valid = 1'b0;
    imem_data  = '0;
    chk("emite_valid", {31'b0, instr_valida}, 32'h1);
    chk("emite_instr", instrucao, instr);
    chk("emite_opcode", {25'b0, opcode}, {25'b0, exp_op});
    chk("emite_pc", pc_atual, ea);
  endtask

  task automatic retire(input logic sb, input logic z, input logic [31:0] imm,
                        input logic [31:0] nxt, input logic exp_err);
    avanca      = 1'b1;
    sinalBranch = sb;
    zero        = z;
    imm_branch  = imm;
    if (!exp_err) exp_q.push_back(nxt);
    step();
    avanca      = 1'b0;
    sinalBranch = 1'b0;
    zero        = 1'b0;
    imm_branch  = '0;
    // Zero-wait throughput: request is up the cycle right after retiring.
    chk("retire_req", {31'b0, imem_req}, {31'b0, !exp_err});
    chk("retire_err", {31'b0, erro_busca}, {31'b0, exp_err});
  endtask

  initial begin
    tab[0] = '{32'h0000_0033, 1'b0, 1'b0, 32'h0,        32'h00, 7'h33, 32'h04};
    tab[1] = '{32'h0000_0033, 1'b0, 1'b0, 32'h0,        32'h04, 7'h33, 32'h08};
    tab[2] = '{32'h0000_0033, 1'b0, 1'b0, 32'h0,        32'h08, 7'h33, 32'h0C};
    tab[3] = '{32'h0000_0033, 1'b0, 1'b0, 32'h0,        32'h0C, 7'h33, 32'h10};
    tab[4] = '{32'h0000_0063, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h10, 7'h63, 32'h08};
    tab[5] = '{32'h0000_0033, 1'b0, 1'b0, 32'h0,        32'h08, 7'h33, 32'h0C};
    tab[6] = '{32'h0000_0033, 1'b0, 1'b0, 32'h0,        32'h0C, 7'h33, 32'h10};
    tab[7] = '{32'h0000_0063, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h10, 7'h63, 32'h14};
    tab[8] = '{32'h00A0_0013, 1'b0, 1'b1, 32'h100,      32'h14, 7'h13, 32'h18};
    tab[9] = '{32'hFE00_0AE3, 1'b1, 1'b1, 32'h8,        32'h18, 7'h63, 32'h20};

    // ---- Table-driven fetch/retire run --------------------------------------
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fetch(tab[i].instr, tab[i].op);
      chk("tab_pc", pc_atual, tab[i].pc);
      retire(tab[i].sb, tab[i].z, tab[i].imm, tab[i].nxt, 1'b0);
    end
    fetch(32'h0000_0033, 7'h33);

    // ---- Stall: avanca low for 5 EMITE cycles --------------------------------
    do_reset();
    fetch(32'h0000_0033, 7'h33);
    retire(1'b0, 1'b0, 32'h0, 32'h4, 1'b0);
    fetch(32'h0000_00B3, 7'h33);
    sinalBranch = 1'b1;
    zero        = 1'b1;
    imm_branch  = 32'h40;
    imem_valid  = 1'b1;
    imem_data   = 32'h1234_5677;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", {31'b0, instr_valida}, 32'h1);
      chk("stall_pc", pc_atual, 32'h4);
      chk("stall_instr", instrucao, 32'h0000_00B3);
    end
    imem_valid = 1'b0;
    imem_data  = '0;
    retire(1'b0, 1'b0, 32'h0, 32'h8, 1'b0);
    fetch(32'h0000_0033, 7'h33);

    // ---- Misaligned branch target -> sticky ERRO -----------------------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      fetch(32'h0000_0033, 7'h33);
      retire(1'b0, 1'b0, 32'h0, 32'(4 * (i + 1)), 1'b0);
    end
    fetch(32'h0000_0063, 7'h63);
    retire(1'b1, 1'b1, 32'h6, 32'h0, 1'b1);
    imem_valid = 1'b1;
    avanca     = 1'b1;
    imem_data  = 32'h0000_0033;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("erro_sticky", {28'b0, erro_busca, imem_req, instr_valida, |opcode}, 32'h8);
      chk("erro_pc", pc_atual, 32'h10);
    end
    imem_valid = 1'b0;
    avanca     = 1'b0;
    imem_data  = '0;

    // ---- Timeout: no response at all ----------------------------------------
    do_reset();
    step();
    begin
      int n = 0;
      while (imem_req && n < 40) begin
        n++;
        step();
      end
      chk("timeout_req_cycles", 32'(n), 32'd15);
    end
    chk("timeout_err", {31'b0, erro_busca}, 32'h1);

    // ---- Timeout boundary: response on the 15th cycle ------------------------
    do_reset();
    step();
    for (int i = 0; i < 14; i++) step();
    chk("t15_req", {31'b0, imem_req}, 32'h1);
    imem_valid = 1'b1;
    imem_data  = 32'h0000_0033;
    step();
    imem_valid = 1'b0;
    imem_data  = '0;
    chk("t15_valid", {31'b0, instr_valida}, 32'h1);
    chk("t15_err", {31'b0, erro_busca}, 32'h0);

    // ---- Async reset mid-BUSCA on PC_RESET=0x100 instance --------------------
    rst1 = 1'b0;
    step();
    chk("r1_req", {31'b0, imem_req1}, 32'h1);
    chk("r1_addr", imem_addr1, 32'h100);
    step();
    #3;
    rst1 = 1'b1;
    #1;
    chk("r1_async_clear", {29'b0, imem_req1, instr_valida1, erro_busca1}, 32'h0);
    chk("r1_async_pc", pc_atual1, 32'h100);
    imem_valid = 1'b1;
    imem_data  = 32'h0000_0033;
    step();
    rst1 = 1'b0;
    step();
    chk("r1_stray_ignored", {31'b0, instr_valida1}, 32'h0);
    chk("r1_restart_req", {31'b0, imem_req1}, 32'h1);
    chk("r1_restart_addr", imem_addr1, 32'h100);
    chk("r1_restart_instr", instrucao1, 32'h0);
    step();
    imem_valid = 1'b0;
    imem_data  = '0;
    chk("r1_fetch_valid", {31'b0, instr_valida1}, 32'h1);
    chk("r1_fetch_op", {25'b0, opcode1}, 32'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
